// File: rtl/minterm_lister.sv
// Scans a captured truth table and streams its minterm indices followed by
// every adjacent minterm pair (first merge step), over a valid/ready output.
module minterm_lister #(
  parameter int N = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [(2**N)-1:0]             table_in,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_kind,
  output logic [N-1:0]                  out_index,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_var,
  output logic [N:0]                    mcount,
  output logic [$clog2((2**N)*N):0]     pcount,
  output logic                          done
);

  localparam int W  = 2**N;
  localparam int VW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(W*N) + 1;

  localparam logic [N-1:0]  I_LAST = N'(W-1);
  localparam logic [VW-1:0] V_LAST = VW'(N-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN_M = 2'd1,
    SCAN_P = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    tbl_q, tbl_d;
  logic [N-1:0]    i_q, i_d;
  logic [VW-1:0]   v_q, v_d;
  logic [N:0]      mcount_q, mcount_d;
  logic [PW-1:0]   pcount_q, pcount_d;
  logic            out_valid_q, out_valid_d;
  logic            out_kind_q, out_kind_d;
  logic [N-1:0]    out_index_q, out_index_d;
  logic [VW-1:0]   out_var_q, out_var_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            advance_s;
  logic            handshake_s;

  // A pair is reported only from its lower member (bit v clear).
  function automatic logic pair_hit(input logic [W-1:0] tbl,
                                    input logic [N-1:0] idx,
                                    input logic [VW-1:0] var_sel);
    logic [N-1:0] upper;
    upper = idx | (N'(1) << var_sel);
    return tbl[idx] && !idx[var_sel] && tbl[upper];
  endfunction

  always_comb begin
    state_d     = state_q;
    tbl_d       = tbl_q;
    i_d         = i_q;
    v_d         = v_q;
    mcount_d    = mcount_q;
    pcount_d    = pcount_q;
    handshake_s = out_valid_q && out_ready;
    advance_s   = !out_valid_q || out_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          tbl_d    = table_in;
          i_d      = '0;
          v_d      = '0;
          mcount_d = '0;
          pcount_d = '0;
          state_d  = SCAN_M;
        end else begin
          state_d  = IDLE;
        end
      end
      SCAN_M: begin
        if (handshake_s) begin
          mcount_d = mcount_q + (N+1)'(1);
        end else begin
          mcount_d = mcount_q;
        end
        if (advance_s) begin
          if (i_q == I_LAST) begin
            i_d     = '0;
            v_d     = '0;
            state_d = SCAN_P;
          end else begin
            i_d     = i_q + N'(1);
          end
        end else begin
          i_d = i_q;
        end
      end
      SCAN_P: begin
        if (handshake_s) begin
          pcount_d = pcount_q + PW'(1);
        end else begin
          pcount_d = pcount_q;
        end
        // v is the inner loop, i the outer loop.
        if (advance_s) begin
          if (v_q == V_LAST) begin
            v_d = '0;
            if (i_q == I_LAST) begin
              state_d = DONE;
            end else begin
              i_d = i_q + N'(1);
            end
          end else begin
            v_d = v_q + VW'(1);
          end
        end else begin
          v_d = v_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Presentation for the next cycle is derived from the next pointers, so a
  // stalled item simply recomputes itself and out_* stay registered.
  always_comb begin
    out_valid_d = 1'b0;
    out_kind_d  = 1'b0;
    out_index_d = '0;
    out_var_d   = '0;
    case (state_d)
      SCAN_M: begin
        out_valid_d = tbl_d[i_d];
        out_index_d = i_d;
      end
      SCAN_P: begin
        out_valid_d = pair_hit(tbl_d, i_d, v_d);
        out_kind_d  = 1'b1;
        out_index_d = i_d;
        out_var_d   = v_d;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == SCAN_M) || (state_d == SCAN_P);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tbl_q       <= '0;
      i_q         <= '0;
      v_q         <= '0;
      mcount_q    <= '0;
      pcount_q    <= '0;
      out_valid_q <= 1'b0;
      out_kind_q  <= 1'b0;
      out_index_q <= '0;
      out_var_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tbl_q       <= tbl_d;
      i_q         <= i_d;
      v_q         <= v_d;
      mcount_q    <= mcount_d;
      pcount_q    <= pcount_d;
      out_valid_q <= out_valid_d;
      out_kind_q  <= out_kind_d;
      out_index_q <= out_index_d;
      out_var_q   <= out_var_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_kind  = out_kind_q;
  assign out_index = out_index_q;
  assign out_var   = out_var_q;
  assign mcount    = mcount_q;
  assign pcount    = pcount_q;

endmodule

// File: tb/tb_minterm_lister.sv
// Scoreboard bench for minterm_lister (N=3): expected items queued from a
// reference enumeration, compared as the DUT presents them.
module tb_minterm_lister;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int NOMINAL_DONE = W + W*N + 1;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] table_in;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic       out_kind;
  logic [2:0] out_index;
  logic [1:0] out_var;
  logic [3:0] mcount;
  logic [5:0] pcount;
  logic       done;

  int n_cmp;
  int n_err;
  int exp_q[$];

  minterm_lister #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .table_in(table_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_index(out_index), .out_var(out_var),
    .mcount(mcount), .pcount(pcount), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int pack_item(input int kind, input int idx, input int vv);
    return (kind << 8) | (idx << 4) | vv;
  endfunction

  // Reference enumeration straight from the truth table.
  task automatic build_expect(input logic [7:0] tbl, output int nm, output int np);
    nm = 0;
    np = 0;
    exp_q.delete();
    for (int i = 0; i < W; i++) begin
      if (tbl[i]) begin
        exp_q.push_back(pack_item(0, i, 0));
        nm++;
      end
    end
    for (int i = 0; i < W; i++) begin
      for (int v = 0; v < N; v++) begin
        if (tbl[i] && (((i >> v) & 1) == 0) && tbl[i | (1 << v)]) begin
          exp_q.push_back(pack_item(1, i, v));
          np++;
        end
      end
    end
  endtask

  task automatic run_scan(input logic [7:0] tbl, input int stall_n, input bit poke);
    int nm, np, done_cyc, left;
    bit pending;
    int got, held;
    build_expect(tbl, nm, np);
    done_cyc = NOMINAL_DONE + stall_n * (nm + np);
    pending  = 1'b0;
    held     = 0;
    left     = 0;
    @(negedge clk);
    start    = 1'b1;
    table_in = tbl;
    @(negedge clk);
    start    = 1'b0;
    table_in = ~tbl;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      start = (poke && (c == 10 || c == done_cyc)) ? 1'b1 : 1'b0;
      check_val("busy", {31'd0, busy}, {31'd0, (c < done_cyc)});
      check_val("done", {31'd0, done}, {31'd0, (c == done_cyc)});
      if (pending) begin
        check_val("valid_hold", {31'd0, out_valid}, 32'd1);
      end
      if (out_valid) begin
        got = pack_item(int'(out_kind), int'(out_index), int'(out_var));
        if (!pending) begin
          if (exp_q.size() == 0) begin
            check_val("extra_item", got, 32'hFFFF);
          end else begin
            check_val("item", got, exp_q.pop_front());
          end
          held    = got;
          pending = 1'b1;
          left    = stall_n;
        end else begin
          check_val("stable", got, held);
        end
      end
      if (pending) begin
        if (left > 0) begin
          out_ready = 1'b0;
          left--;
        end else begin
          out_ready = 1'b1;
          pending   = 1'b0;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_val("valid_idle", {31'd0, out_valid}, 32'd0);
    check_val("leftover", exp_q.size(), 32'd0);
    check_val("mcount", {28'd0, mcount}, nm);
    check_val("pcount", {26'd0, pcount}, np);
    if (poke) begin
      for (int k = 0; k < 3; k++) begin
        check_val("idle_busy", {31'd0, busy}, 32'd0);
        check_val("idle_done", {31'd0, done}, 32'd0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    bit found;
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    table_in  = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_val("rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_mcount", {28'd0, mcount}, 32'd0);
    check_val("rst_pcount", {26'd0, pcount}, 32'd0);
    check_val("rst_fields", {26'd0, out_kind, out_index, out_var}, 32'd0);

    run_scan(8'b00101110, 0, 1'b0);
    run_scan(8'h00, 0, 1'b0);
    run_scan(8'hFF, 0, 1'b0);
    run_scan(8'b00101110, 3, 1'b0);
    run_scan(8'b01101001, 1, 1'b0);
    run_scan(8'b11000011, 0, 1'b1);

    // Reset while minterm 2 is on the output.
    @(negedge clk);
    start    = 1'b1;
    table_in = 8'b00101110;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b1;
    found     = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (out_valid && out_kind == 1'b0 && out_index == 3'd2) begin
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check_val("found_m2", {31'd0, found}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_mcount", {28'd0, mcount}, 32'd0);
    check_val("mid_rst_pcount", {26'd0, pcount}, 32'd0);
    run_scan(8'h01, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/minterm_lister.md
Name: minterm_lister

Overview:
- Reverse direction of the truth-table builder. The builder sweeps input combinations of an N-variable function and records output s per row.
- This block takes a recorded truth table and serially emits:
  - its canonical SOP minterm indices;
  - every adjacent minterm pair, i.e. the first Quine-McCluskey / K-map merge step.
- Output is a valid/ready stream consumed by the display/checker bench that prints expressions and compares them against the minimized form.

Parameters:
- N, 3, number of input variables. Index bit N-1 = a (MSB), bit 0 = c (LSB).
- W, 2**N, number of truth-table rows (derived; do not override).
- VW, max(1, clog2(N)), width of the variable-number field (derived).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a scan; sampled only in IDLE
- table_in  input  W  truth table; bit i = function value at row i; captured on accepted start
- busy  output  1  high in SCAN_M and SCAN_P
- out_valid  output  1  an item is presented
- out_ready  input  1  consumer accepts the item when out_valid && out_ready
- out_kind  output  1  0 = minterm, 1 = adjacent pair
- out_index  output  N  minterm index (kind 0), or lower member of the pair with bit out_var = 0 (kind 1)
- out_var  output  VW  kind 1: variable bit in which the pair differs; kind 0: 0
- mcount  output  N+1  minterms emitted in the current/last scan
- pcount  output  clog2(W*N)+1  pairs emitted in the current/last scan
- done  output  1  one-cycle pulse when a scan completes

Behaviour:
- Reset (synchronous, any state):
  - State -> IDLE.
  - out_valid, busy, done, mcount, pcount, out_kind, out_index, out_var all 0.
  - Internal pointers cleared.
  - An item being presented is dropped, not completed.
- States: IDLE, SCAN_M, SCAN_P, DONE.
- IDLE:
  - start=1 at an edge captures table_in into a table register, clears mcount/pcount, sets pointer i=0, v=0, and enters SCAN_M.
  - start=0 stays in IDLE.
- SCAN_M: one candidate row i per cycle.
  - hit = tbl[i].
  - out_valid = hit, kind=0, out_index=i, out_var=0.
  - Pointer advances when !hit or (hit && out_ready). mcount increments on the handshake.
  - Advancing from i=W-1 goes to SCAN_P with i=0, v=0.
- SCAN_P: candidate (i, v); v is the inner loop 0..N-1, i is the outer loop 0..W-1.
  - hit = tbl[i] && !i[v] && tbl[i | (1<<v)].
  - out_valid = hit, kind=1, out_index=i, out_var=v.
  - Advance and count rules as in SCAN_M, with pcount.
  - Advancing from (W-1, N-1) goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Handshake rules:
  - out_valid and all out_* fields are driven from registers only. No combinational path from out_ready to out_valid.
  - While out_valid && !out_ready, all out_* fields remain stable.
  - out_valid never drops without a handshake, except on reset.
- Latency: with out_ready held at 1, a scan takes exactly W + W*N cycles regardless of content.
  - Start accepted at edge 0: busy in cycles 1..W+W*N (N=3: 1..32), done in cycle W+W*N+1 (N=3: 33).
  - Each stall cycle adds one cycle.
- Boundary conditions:
  - start while busy or in DONE: ignored.
  - table_in changes during a scan: no effect (captured copy used).
  - All-zero table: no items emitted, mcount=pcount=0, done at the nominal cycle.
  - All-ones table: W minterms and N*W/2 pairs emitted (N=3: 8 and 12).
  - mcount/pcount hold their values after DONE until the next accepted start or reset.
  - Pair emitted once only: from its lower member, never from the upper.

Test Plan:
- Truth table 8'b00101110 (minterms 1,2,3,5; the function a'b'c + a'bc' + a'bc + ab'c), out_ready=1 -> minterms 1,2,3,5, then pairs (1,v1),(1,v2),(2,v0); mcount=4, pcount=3; done in cycle 33.
- table 8'h00 -> out_valid never 1; busy cycles 1..32; done=1 only in cycle 33.
- table 8'hFF -> 8 minterms in order 0..7, then 12 pairs ending (6,v0); mcount=8, pcount=12.
- Backpressure: table 8'b00101110, out_ready low for 3 cycles on each item -> same item sequence; fields stable during stalls; done in cycle 33+3*7=54.
- Reset high for 1 cycle while minterm 2 is presented -> next cycle out_valid=0, busy=0, counts 0. A new start with table 8'h01 then emits only minterm 0 and done.
- start pulsed while busy and again in the DONE cycle -> both ignored; exactly one done pulse; IDLE afterwards.
